// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler.
//   state_e   : car controller states
//   DIR_UP/DIR_DOWN : travel direction encoding
//   state_cmd : actuator command vector asserted while in a given state
package elevator_pkg;

   localparam int unsigned DEF_FLOORS     = 6;
   localparam int unsigned DEF_DOOR_TICKS = 8;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MOVE_UP    = 3'd1,
      MOVE_DOWN  = 3'd2,
      DOOR_OPEN  = 3'd3,
      DOOR_CLOSE = 3'd4
   } state_e;

   // {engine_up, engine_down, open_door, close_door} for a state
   function automatic logic [3:0] state_cmd(state_e s);
      case (s)
         MOVE_UP:    return 4'b1000;
         MOVE_DOWN:  return 4'b0100;
         DOOR_OPEN:  return 4'b0010;
         DOOR_CLOSE: return 4'b0001;
         default:    return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/elevator_call_mask.sv
// Combinational call evaluation relative to one floor index.
//   i_car/i_up/i_down : latched call vectors (floor 0 = bit 0)
//   i_floor           : floor the evaluation is made for
//   o_above_c/o_below_c/o_here_c : any call above / below / at i_floor
//   o_stop_up_c/o_stop_down_c    : car travelling up/down should stop at i_floor
module elevator_call_mask
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS = DEF_FLOORS,
   parameter int unsigned FW     = $clog2(FLOORS)
) (
   input  logic [FLOORS-1:0] i_car,
   input  logic [FLOORS-1:0] i_up,
   input  logic [FLOORS-1:0] i_down,
   input  logic [FW-1:0]     i_floor,
   output logic              o_above_c,
   output logic              o_below_c,
   output logic              o_here_c,
   output logic              o_stop_up_c,
   output logic              o_stop_down_c
);

   logic [FLOORS-1:0] w_any;
   logic              w_car_here;
   logic              w_up_here;
   logic              w_down_here;

   assign w_any = i_car | i_up | i_down;

   // Scan every floor against the index; also picks out the per-type bits at i_floor.
   always_comb begin
      o_above_c   = 1'b0;
      o_below_c   = 1'b0;
      o_here_c    = 1'b0;
      w_car_here  = 1'b0;
      w_up_here   = 1'b0;
      w_down_here = 1'b0;
      for (int i = 0; i < int'(FLOORS); i++) begin
         if (FW'(i) > i_floor) o_above_c = o_above_c | w_any[i];
         if (FW'(i) < i_floor) o_below_c = o_below_c | w_any[i];
         if (FW'(i) == i_floor) begin
            o_here_c    = w_any[i];
            w_car_here  = i_car[i];
            w_up_here   = i_up[i];
            w_down_here = i_down[i];
         end
      end
   end

   assign o_stop_up_c   = w_car_here | w_up_here   | ~o_above_c;
   assign o_stop_down_c = w_car_here | w_down_here | ~o_below_c;

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car collective (SCAN) scheduler with motion and door sequencing.
//   clk, reset (async, active low)
//   btn_num_in / btn_up_out / btn_down_out : car and hall call buttons
//   open_btn / close_btn : door requests;  floor_tick : one pulse per floor travelled
//   engine_up / engine_down / open_door / close_door : registered actuator commands
//   level_display : one-hot current floor;  pending : latched call lamps
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS     = DEF_FLOORS,
   parameter int unsigned DOOR_TICKS = DEF_DOOR_TICKS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] btn_num_in,
   input  logic [FLOORS-1:0] btn_up_out,
   input  logic [FLOORS-1:0] btn_down_out,
   input  logic              open_btn,
   input  logic              close_btn,
   input  logic              floor_tick,
   output logic              engine_up,
   output logic              engine_down,
   output logic              open_door,
   output logic              close_door,
   output logic [FLOORS-1:0] level_display,
   output logic [FLOORS-1:0] pending
);

   localparam int unsigned       FW        = $clog2(FLOORS);
   localparam int unsigned       TW        = $clog2(DOOR_TICKS + 1);
   localparam logic [FW-1:0]     TOP_FLOOR = FW'(FLOORS - 1);
   localparam logic [TW-1:0]     T_LOAD    = TW'(DOOR_TICKS);
   localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

   state_e            r_state;
   logic [FW-1:0]     r_floor;
   logic              r_dir;
   logic [FLOORS-1:0] r_car, r_up, r_down;
   logic [TW-1:0]     r_timer;
   logic [3:0]        r_cmd;
   logic [FLOORS-1:0] r_level, r_pending;

   logic [FLOORS-1:0] w_floor_oh, w_eval_oh, w_lat_mask;
   logic [FLOORS-1:0] w_car_lat, w_up_lat, w_down_lat;
   logic [FLOORS-1:0] w_clr_car, w_clr_up, w_clr_down;
   logic [FLOORS-1:0] w_car_nxt, w_up_nxt, w_down_nxt;
   logic [FW-1:0]     w_eval_floor;
   logic              w_above, w_below, w_here, w_stop_up, w_stop_down;
   logic              w_enter_open, w_ahead, w_behind, w_flip;

   // Call latching; presses at the floor whose doors are open are dropped.
   assign w_floor_oh = FLOORS'(1) << r_floor;
   assign w_lat_mask = (r_state == DOOR_OPEN) ? ~w_floor_oh : '1;
   assign w_car_lat  = r_car  | (btn_num_in & w_lat_mask);
   assign w_up_lat   = r_up   | (btn_up_out & UP_MASK & w_lat_mask);
   assign w_down_lat = r_down | (btn_down_out & DOWN_MASK & w_lat_mask);

   // Decisions are made for the arriving floor when a tick lands while moving.
   always_comb begin
      w_eval_floor = r_floor;
      if (floor_tick && (r_state == MOVE_UP) && (r_floor != TOP_FLOOR))
         w_eval_floor = r_floor + FW'(1);
      else if (floor_tick && (r_state == MOVE_DOWN) && (r_floor != '0))
         w_eval_floor = r_floor - FW'(1);
   end
   assign w_eval_oh = FLOORS'(1) << w_eval_floor;

   elevator_call_mask #(
      .FLOORS (FLOORS),
      .FW     (FW)
   ) u_call_mask (
      .i_car         (w_car_lat),
      .i_up          (w_up_lat),
      .i_down        (w_down_lat),
      .i_floor       (w_eval_floor),
      .o_above_c     (w_above),
      .o_below_c     (w_below),
      .o_here_c      (w_here),
      .o_stop_up_c   (w_stop_up),
      .o_stop_down_c (w_stop_down)
   );

   // Every path that lands in DOOR_OPEN shares the same entry actions.
   always_comb begin
      w_enter_open = 1'b0;
      case (r_state)
         IDLE:       w_enter_open = open_btn | w_here;
         MOVE_UP:    w_enter_open = floor_tick & w_stop_up;
         MOVE_DOWN:  w_enter_open = floor_tick & w_stop_down;
         DOOR_CLOSE: w_enter_open = open_btn;
         default:    w_enter_open = 1'b0;
      endcase
   end

   // Door-entry call clearing: the hall call in the travel direction always goes;
   // both go when nothing lies ahead, and the car turns round if calls lie behind.
   assign w_ahead    = (r_dir == DIR_UP) ? w_above : w_below;
   assign w_behind   = (r_dir == DIR_UP) ? w_below : w_above;
   assign w_flip     = w_enter_open & ~w_ahead & w_behind;
   assign w_clr_car  = w_enter_open ? w_eval_oh : '0;
   assign w_clr_up   = (w_enter_open && ((r_dir == DIR_UP) || !w_ahead)) ? w_eval_oh : '0;
   assign w_clr_down = (w_enter_open && ((r_dir == DIR_DOWN) || !w_ahead)) ? w_eval_oh : '0;
   assign w_car_nxt  = w_car_lat  & ~w_clr_car;
   assign w_up_nxt   = w_up_lat   & ~w_clr_up;
   assign w_down_nxt = w_down_lat & ~w_clr_down;

   // Controller FSM with registered commands, display and lamps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_floor   <= '0;
         r_dir     <= DIR_UP;
         r_car     <= '0;
         r_up      <= '0;
         r_down    <= '0;
         r_timer   <= '0;
         r_cmd     <= '0;
         r_level   <= FLOORS'(1);
         r_pending <= '0;
      end else begin
         r_car     <= w_car_nxt;
         r_up      <= w_up_nxt;
         r_down    <= w_down_nxt;
         r_pending <= w_car_nxt | w_up_nxt | w_down_nxt;
         r_floor   <= w_eval_floor;
         r_level   <= w_eval_oh;
         if (w_flip) r_dir <= ~r_dir;

         if (w_enter_open) begin
            r_state <= DOOR_OPEN;
            r_timer <= T_LOAD;
            r_cmd   <= state_cmd(DOOR_OPEN);
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_above && ((r_dir == DIR_UP) || !w_below)) begin
                     r_state <= MOVE_UP;
                     r_dir   <= DIR_UP;
                     r_cmd   <= state_cmd(MOVE_UP);
                  end else if (w_below) begin
                     r_state <= MOVE_DOWN;
                     r_dir   <= DIR_DOWN;
                     r_cmd   <= state_cmd(MOVE_DOWN);
                  end
               end
               MOVE_UP, MOVE_DOWN: ;
               DOOR_OPEN: begin
                  // open_btn takes precedence over close_btn
                  if (open_btn) begin
                     r_timer <= T_LOAD;
                  end else if (close_btn || (r_timer == TW'(1))) begin
                     r_state <= DOOR_CLOSE;
                     r_timer <= T_LOAD;
                     r_cmd   <= state_cmd(DOOR_CLOSE);
                  end else begin
                     r_timer <= r_timer - TW'(1);
                  end
               end
               DOOR_CLOSE: begin
                  if (r_timer == TW'(1)) begin
                     r_state <= IDLE;
                     r_cmd   <= state_cmd(IDLE);
                  end else begin
                     r_timer <= r_timer - TW'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cmd   <= state_cmd(IDLE);
               end
            endcase
         end
      end
   end

   assign engine_up     = r_cmd[3];
   assign engine_down   = r_cmd[2];
   assign open_door     = r_cmd[1];
   assign close_door    = r_cmd[0];
   assign level_display = r_level;
   assign pending       = r_pending;

endmodule
